// File: rtl/vga_sink_monitor.sv
// vga_sink_monitor: receive-side VGA timing checker.
//
// Registers hsync/vsync/RGB once in the pixel domain, measures line and frame geometry, locks
// after LOCK_FRAMES consecutive frames of identical geometry, and pulses timing_err on a
// geometry change while locked or on counter overflow.
//
// Optional feature: define VGA_SINK_CRC_EN to build a CRC-16-CCITT over each frame's pixels.
// With the macro undefined, no CRC logic exists and frame_crc is tied to zero.
//
// Ports:
//   clk_pixel, rstn_pixel       pixel clock, asynchronous active-low reset
//   vga_hsync, vga_vsync        sync inputs (polarity set by SYNC_ACTIVE_LOW)
//   vga_red/green/blue [3:0]    pixel colour
//   h_total, h_sync_len         clocks per line, clocks of hsync asserted
//   v_total, v_sync_len         lines per frame, lines of vsync asserted
//   locked                      geometry stable
//   frame_done, timing_err      single-cycle pulses
//   frame_crc [15:0]            CRC of previous frame (0 when CRC is not built)
module vga_sink_monitor #(
    parameter int unsigned H_BITS          = 12,
    parameter int unsigned V_BITS          = 11,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES     = 2
) (
    input  logic              clk_pixel,
    input  logic              rstn_pixel,
    input  logic              vga_hsync,
    input  logic              vga_vsync,
    input  logic [3:0]        vga_red,
    input  logic [3:0]        vga_green,
    input  logic [3:0]        vga_blue,
    output logic [H_BITS-1:0] h_total,
    output logic [H_BITS-1:0] h_sync_len,
    output logic [V_BITS-1:0] v_total,
    output logic [V_BITS-1:0] v_sync_len,
    output logic              locked,
    output logic              frame_done,
    output logic              timing_err,
    output logic [15:0]       frame_crc
);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    localparam logic [H_BITS-1:0] HMax       = '1;
    localparam logic [V_BITS-1:0] VMax       = '1;
    localparam logic [3:0]        LockTarget = 4'(LOCK_FRAMES - 1);

    state_e            state_q, state_d;
    // Sync history held in "asserted = 1" form so polarity is handled once at the input.
    logic              hs1_q, vs1_q, hs2_q, vs2_q;
    logic [H_BITS-1:0] h_cnt_q, h_cnt_d, hs_len_q, hs_len_d;
    logic [V_BITS-1:0] line_cnt_q, line_cnt_d, vs_len_q, vs_len_d;
    logic [H_BITS-1:0] h_total_q, h_total_d, h_sync_len_q, h_sync_len_d;
    logic [V_BITS-1:0] v_total_q, v_total_d, v_sync_len_q, v_sync_len_d;
    logic [H_BITS-1:0] prev_h_q, prev_h_d;
    logic [3:0]        match_q, match_d;
    logic              locked_q, locked_d;
    logic              frame_done_q, frame_done_d;
    logic              timing_err_q, timing_err_d;

    logic              hs_lead, hs_trail, vs_lead, vs_trail;
    logic [H_BITS-1:0] h_cnt_inc;
    logic [V_BITS-1:0] line_inc, v_total_new;
    logic [3:0]        match_inc;
    logic              h_ovf, v_ovf;

    assign hs_lead  = hs1_q & ~hs2_q;
    assign hs_trail = ~hs1_q & hs2_q;
    assign vs_lead  = vs1_q & ~vs2_q;
    assign vs_trail = ~vs1_q & vs2_q;

    assign h_cnt_inc   = h_cnt_q + 1'b1;
    assign line_inc    = line_cnt_q + 1'b1;
    assign match_inc   = match_q + 1'b1;
    // A line whose hsync edge coincides with the vsync edge belongs to the ending frame.
    assign v_total_new = line_cnt_q + {{(V_BITS-1){1'b0}}, hs_lead};

    // Overflow fires once, on the cycle the counter first reaches all-ones.
    assign h_ovf = ~hs_lead & (h_cnt_inc == HMax) & (h_cnt_q != HMax);
    assign v_ovf = ~vs_lead & hs_lead & (line_inc == VMax) & (line_cnt_q != VMax);

    always_comb begin
        h_cnt_d    = h_cnt_q;
        hs_len_d   = hs_len_q;
        line_cnt_d = line_cnt_q;
        vs_len_d   = vs_len_q;

        if (hs_lead) begin
            h_cnt_d = '0;
        end else if (h_cnt_q != HMax) begin
            h_cnt_d = h_cnt_inc;
        end

        if (hs_trail) begin
            hs_len_d = '0;
        end else if (hs1_q) begin
            hs_len_d = hs_len_q + 1'b1;
        end

        if (vs_lead) begin
            line_cnt_d = '0;
        end else if (hs_lead && line_cnt_q != VMax) begin
            line_cnt_d = line_inc;
        end

        if (vs_lead) begin
            vs_len_d = {{(V_BITS-1){1'b0}}, hs_lead};
        end else if (vs_trail) begin
            vs_len_d = '0;
        end else if (hs_lead && vs1_q) begin
            vs_len_d = vs_len_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        locked_d     = locked_q;
        frame_done_d = 1'b0;
        timing_err_d = 1'b0;
        h_total_d    = h_total_q;
        h_sync_len_d = h_sync_len_q;
        v_total_d    = v_total_q;
        v_sync_len_d = v_sync_len_q;
        prev_h_d     = prev_h_q;

        // Nothing is published while searching: the frame in progress is partial.
        if (state_q != StSearch) begin
            if (hs_lead)  h_total_d    = h_cnt_inc;
            if (hs_trail) h_sync_len_d = hs_len_q;
            if (vs_trail) v_sync_len_d = vs_len_q;
            if (vs_lead) begin
                frame_done_d = 1'b1;
                v_total_d    = v_total_new;
                prev_h_d     = h_total_d;
            end
        end

        case (state_q)
            StSearch: begin
                if (vs_lead) state_d = StMeasure;
            end
            StMeasure: begin
                if (vs_lead) begin
                    if (h_total_d == prev_h_q && v_total_new == v_total_q) begin
                        match_d = match_inc;
                        if (match_inc >= LockTarget) begin
                            state_d  = StLocked;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            StLocked: begin
                if ((hs_lead && h_cnt_inc != h_total_q) ||
                    (vs_lead && v_total_new != v_total_q)) begin
                    timing_err_d = 1'b1;
                    locked_d     = 1'b0;
                    match_d      = '0;
                    state_d      = StMeasure;
                end
            end
            default: state_d = StSearch;
        endcase

        // Overflow means the input has lost timing entirely; start over, forgetting history
        // so the next measured frame cannot match stale geometry.
        if (h_ovf || v_ovf) begin
            timing_err_d = 1'b1;
            locked_d     = 1'b0;
            match_d      = '0;
            prev_h_d     = '0;
            state_d      = StSearch;
        end
    end

    always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
        if (!rstn_pixel) begin
            state_q      <= StSearch;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            hs2_q        <= 1'b0;
            vs2_q        <= 1'b0;
            h_cnt_q      <= '0;
            hs_len_q     <= '0;
            line_cnt_q   <= '0;
            vs_len_q     <= '0;
            h_total_q    <= '0;
            h_sync_len_q <= '0;
            v_total_q    <= '0;
            v_sync_len_q <= '0;
            prev_h_q     <= '0;
            match_q      <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs1_q        <= vga_hsync ^ SYNC_ACTIVE_LOW;
            vs1_q        <= vga_vsync ^ SYNC_ACTIVE_LOW;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
            h_cnt_q      <= h_cnt_d;
            hs_len_q     <= hs_len_d;
            line_cnt_q   <= line_cnt_d;
            vs_len_q     <= vs_len_d;
            h_total_q    <= h_total_d;
            h_sync_len_q <= h_sync_len_d;
            v_total_q    <= v_total_d;
            v_sync_len_q <= v_sync_len_d;
            prev_h_q     <= prev_h_d;
            match_q      <= match_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            timing_err_q <= timing_err_d;
        end
    end

    assign h_total    = h_total_q;
    assign h_sync_len = h_sync_len_q;
    assign v_total    = v_total_q;
    assign v_sync_len = v_sync_len_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign timing_err = timing_err_q;

`ifdef VGA_SINK_CRC_EN
    logic [11:0] rgb1_q;
    logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

    // CRC-16-CCITT, 12 data bits per cycle, MSB first.
    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_comb begin
        // The pixel on the vsync edge cycle is the first of the new frame.
        crc_d       = crc12(vs_lead ? 16'hFFFF : crc_q, rgb1_q);
        frame_crc_d = frame_crc_q;
        if (vs_lead && state_q != StSearch) frame_crc_d = crc_q;
    end

    always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
        if (!rstn_pixel) begin
            rgb1_q      <= '0;
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
        end else begin
            rgb1_q      <= {vga_red, vga_green, vga_blue};
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    logic unused_rgb;
    assign unused_rgb = ^{vga_red, vga_green, vga_blue};
    assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sink_monitor.sv
// Directed bench for vga_sink_monitor. A scaled 640x480-style raster (active-low syncs,
// vsync leading edge coincident with hsync) drives one instance; a tiny active-high raster with
// a non-coincident vsync edge drives a second instance.
module tb_vga_sink_monitor;

    localparam int HT = 80;  // clocks per line
    localparam int HS = 12;  // hsync clocks
    localparam int VT = 45;  // lines per frame
    localparam int VS = 2;   // vsync lines
    localparam int TT = 20;
    localparam int TS = 3;
    localparam int TV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic        hs_m, vs_m, hs_t, vs_t;
    logic [3:0]  r_m, g_m, b_m, r_t, g_t, b_t;
    logic [11:0] ht_m, hsl_m, ht_t, hsl_t;
    logic [10:0] vt_m, vsl_m, vt_t, vsl_t;
    logic        lock_m, fd_m, err_m, lock_t, fd_t, err_t;
    logic [15:0] crc_m, crc_t;

    vga_sink_monitor dut (
        .clk_pixel(clk), .rstn_pixel(rstn), .vga_hsync(hs_m), .vga_vsync(vs_m),
        .vga_red(r_m), .vga_green(g_m), .vga_blue(b_m),
        .h_total(ht_m), .h_sync_len(hsl_m), .v_total(vt_m), .v_sync_len(vsl_m),
        .locked(lock_m), .frame_done(fd_m), .timing_err(err_m), .frame_crc(crc_m)
    );

    vga_sink_monitor #(.SYNC_ACTIVE_LOW(1'b0)) dut_t (
        .clk_pixel(clk), .rstn_pixel(rstn), .vga_hsync(hs_t), .vga_vsync(vs_t),
        .vga_red(r_t), .vga_green(g_t), .vga_blue(b_t),
        .h_total(ht_t), .h_sync_len(hsl_t), .v_total(vt_t), .v_sync_len(vsl_t),
        .locked(lock_t), .frame_done(fd_t), .timing_err(err_t), .frame_crc(crc_t)
    );

    int n_vec = 0;
    int n_err = 0;
    int fd_m_cnt = 0, err_m_cnt = 0, fd_t_cnt = 0, err_t_cnt = 0;
    int line_m = 0, line_t = 0;
    int fd0, err0, tfd0, terr0;
    logic [15:0] exp_crc;

    always @(negedge clk) begin
        if (fd_m)  fd_m_cnt++;
        if (err_m) err_m_cnt++;
        if (fd_t)  fd_t_cnt++;
        if (err_t) err_t_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic main_line(input int len);
        int pos;
        pos = line_m % VT;
        for (int c = 0; c < len; c++) begin
            hs_m = (c < HS) ? 1'b0 : 1'b1;
            vs_m = (pos < VS) ? 1'b0 : 1'b1;
            {r_m, g_m, b_m} = 12'(c * 7 + pos);
            tick();
        end
        line_m++;
    endtask

    task automatic main_to(input int target);
        while (line_m < target) main_line(HT);
    endtask

    task automatic tiny_to(input int target);
        int pos;
        while (line_t < target) begin
            pos = line_t % TV;
            for (int c = 0; c < TT; c++) begin
                hs_t = (c < TS);
                vs_t = (pos == 0 && c >= 5) || (pos == 1) || (pos == 2 && c < 5);
                tick();
            end
            line_t++;
        end
    endtask

    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    initial begin
        rstn = 1'b0;
        hs_m = 1'b1; vs_m = 1'b1; {r_m, g_m, b_m} = 12'h000;
        hs_t = 1'b0; vs_t = 1'b0; {r_t, g_t, b_t} = 12'hFFF;
`ifdef VGA_SINK_CRC_EN
        exp_crc = 16'hFFFF;
        for (int i = 0; i < TT * TV; i++) exp_crc = crc12(exp_crc, 12'hFFF);
`else
        exp_crc = 16'h0000;
`endif
        repeat (3) tick();
        check("rst_h_total", 32'(ht_m), 0);
        check("rst_h_sync_len", 32'(hsl_m), 0);
        check("rst_v_total", 32'(vt_m), 0);
        check("rst_v_sync_len", 32'(vsl_m), 0);
        check("rst_locked", 32'(lock_m), 0);
        check("rst_frame_done", 32'(fd_m), 0);
        check("rst_timing_err", 32'(err_m), 0);
        check("rst_frame_crc", 32'(crc_m), 0);

        // Run into the second frame, then reset mid-line.
        rstn = 1'b1;
        main_to(65);
        check("pre_rst_h_total", 32'(ht_m), HT);
        check("pre_rst_v_total", 32'(vt_m), VT);
        #2 rstn = 1'b0;
        #1;
        check("midrst_h_total", 32'(ht_m), 0);
        check("midrst_v_total", 32'(vt_m), 0);
        check("midrst_h_sync_len", 32'(hsl_m), 0);
        main_to(75);
        rstn = 1'b1;
        fd0  = fd_m_cnt;
        err0 = err_m_cnt;

        main_to(VT * 2 + 3);
        check("search_no_frame_done", 32'(fd_m_cnt - fd0), 0);
        check("search_locked", 32'(lock_m), 0);
        check("search_v_total", 32'(vt_m), 0);

        main_to(VT * 3 + 3);
        check("f1_frame_done", 32'(fd_m_cnt - fd0), 1);
        check("f1_locked", 32'(lock_m), 0);
        check("f1_h_total", 32'(ht_m), HT);
        check("f1_h_sync_len", 32'(hsl_m), HS);
        check("f1_v_total", 32'(vt_m), VT);
        check("f1_v_sync_len", 32'(vsl_m), VS);

        main_to(VT * 4 + 3);
        check("f2_frame_done", 32'(fd_m_cnt - fd0), 2);
        check("f2_locked", 32'(lock_m), 1);
        check("f2_no_err", 32'(err_m_cnt - err0), 0);

        // One stretched line while locked.
        main_to(VT * 4 + 20);
        main_line(HT + 1);
        for (int c = 0; c < HT; c++) begin
            hs_m = (c < HS) ? 1'b0 : 1'b1;
            vs_m = 1'b1;
            tick();
            if (c == 1) begin
                check("stretch_err_pulse", 32'(err_m), 1);
                check("stretch_h_total", 32'(ht_m), HT + 1);
                check("stretch_unlocked", 32'(lock_m), 0);
            end
            if (c == 2) check("stretch_err_single", 32'(err_m), 0);
        end
        line_m++;
        main_to(VT * 6 + 3);
        check("relock", 32'(lock_m), 1);
        check("relock_err_count", 32'(err_m_cnt - err0), 1);
        check("relock_frame_done", 32'(fd_m_cnt - fd0), 4);

        // hsync held deasserted long enough to overflow the 12-bit line counter.
        main_to(VT * 7);
        err0 = err_m_cnt;
        hs_m = 1'b1;
        vs_m = 1'b1;
        repeat (4100) tick();
        check("ovf_err_count", 32'(err_m_cnt - err0), 1);
        check("ovf_unlocked", 32'(lock_m), 0);
        fd0 = fd_m_cnt;
        main_to(VT * 7 + 3);
        check("ovf_search_no_fd", 32'(fd_m_cnt - fd0), 0);
        main_to(VT * 8 + 3);
        check("ovf_remeasure_fd", 32'(fd_m_cnt - fd0), 1);
        check("ovf_remeasure_v_total", 32'(vt_m), VT);
`ifndef VGA_SINK_CRC_EN
        check("main_frame_crc_off", 32'(crc_m), 0);
`endif

        // Tiny active-high mode on the second instance.
        rstn = 1'b0;
        repeat (2) tick();
        rstn  = 1'b1;
        tfd0  = fd_t_cnt;
        terr0 = err_t_cnt;
        tiny_to(3);
        check("tiny_search_fd", 32'(fd_t_cnt - tfd0), 0);
        tiny_to(TV + 3);
        check("tiny_frame_done", 32'(fd_t_cnt - tfd0), 1);
        check("tiny_h_total", 32'(ht_t), TT);
        check("tiny_h_sync_len", 32'(hsl_t), TS);
        check("tiny_v_total", 32'(vt_t), TV);
        check("tiny_v_sync_len", 32'(vsl_t), 2);
        check("tiny_not_locked", 32'(lock_t), 0);
        check("tiny_crc_f1", 32'(crc_t), 32'(exp_crc));
        tiny_to(2 * TV + 3);
        check("tiny_locked", 32'(lock_t), 1);
        check("tiny_crc_f2", 32'(crc_t), 32'(exp_crc));
        tiny_to(3 * TV + 3);
        check("tiny_crc_f3", 32'(crc_t), 32'(exp_crc));
        check("tiny_still_locked", 32'(lock_t), 1);
        check("tiny_no_err", 32'(err_t_cnt - terr0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
